// File: rtl/step_pulse_gen.sv
// Down-counting step-pulse generator: one command emits num_steps STEP pulses at period_eff spacing.
// Optional abort input enabled by defining STEP_ABORT_EN.
module step_pulse_gen #(
  parameter int CNT_W   = 28,
  parameter int STEP_W  = 16,
  parameter int PULSE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  period,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              dir_in,
`ifdef STEP_ABORT_EN
  input  logic              abort,
`endif
  output logic              step,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0]  PW   = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0]  MINP = CNT_W'(PULSE_W + 1);
  localparam logic [CNT_W-1:0]  C1   = CNT_W'(1);
  localparam logic [STEP_W-1:0] S1   = STEP_W'(1);

  state_t            state, nstate;
  logic [CNT_W-1:0]  cnt, ncnt;
  logic [CNT_W-1:0]  per, nper;
  logic [STEP_W-1:0] nsl;
  logic              ndir;
  logic              abort_i;

`ifdef STEP_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nper   = per;
    nsl    = steps_left;
    ndir   = dir;
    unique case (state)
      IDLE: begin
        if (start) begin
          // clamp keeps the LOW phase at least one cycle long
          nper = (period < MINP) ? MINP : period;
          ndir = dir_in;
          if (num_steps == '0) begin
            nstate = DONE;
            ncnt   = '0;
          end else begin
            nstate = HIGH;
            ncnt   = PW - C1;
            nsl    = num_steps - S1;
          end
        end
      end
      HIGH: begin
        if (abort_i) begin
          nstate = DONE;
          ncnt   = '0;
          nsl    = '0;
        end else if (cnt == '0) begin
          nstate = LOW;
          ncnt   = per - PW - C1;
        end else begin
          ncnt = cnt - C1;
        end
      end
      LOW: begin
        if (abort_i) begin
          nstate = DONE;
          ncnt   = '0;
          nsl    = '0;
        end else if (cnt == '0) begin
          if (steps_left != '0) begin
            nstate = HIGH;
            ncnt   = PW - C1;
            nsl    = steps_left - S1;
          end else begin
            nstate = DONE;
            ncnt   = '0;
          end
        end else begin
          ncnt = cnt - C1;
        end
      end
      DONE: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      per        <= '0;
      steps_left <= '0;
      dir        <= 1'b0;
      step       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      per        <= nper;
      steps_left <= nsl;
      dir        <= ndir;
      step       <= (nstate == HIGH);
      busy       <= (nstate != IDLE);
      done       <= (nstate == DONE);
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Randomized bench for step_pulse_gen against a per-command timing model.
// Abort stimulus is compiled in when STEP_ABORT_EN is defined.
module tb_step_pulse_gen;

  localparam int CW = 28;
  localparam int SW = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] period;
  logic [SW-1:0] num_steps;
  logic          dir_in;
`ifdef STEP_ABORT_EN
  logic          abort;
`endif
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;
  logic [SW-1:0] steps_left;

  int checks = 0;
  int errors = 0;

  bit m_act = 1'b0;
  bit m_dir = 1'b0;
  int m_t, m_tend, m_pe, m_num;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .CNT_W  (CW),
    .STEP_W (SW),
    .PULSE_W(PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .period    (period),
    .num_steps (num_steps),
    .dir_in    (dir_in),
`ifdef STEP_ABORT_EN
    .abort     (abort),
`endif
    .step      (step),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // compare this cycle, drive this cycle's inputs, advance the model
  task automatic tick(input bit r, input bit s, input int per,
                      input int num, input bit d, input bit ab);
    int e_step, e_busy, e_done, e_sl;
    e_step = 0; e_busy = 0; e_done = 0; e_sl = 0;
    if (m_act) begin
      e_busy = 1;
      e_done = (m_t == m_tend) ? 1 : 0;
      if (m_t < m_tend) begin
        e_step = (((m_t - 1) % m_pe) < PW) ? 1 : 0;
        e_sl   = m_num - ((m_t - 1) / m_pe + 1);
      end
    end
    chk("step", 32'(step), 32'(e_step));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("steps_left", 32'(steps_left), 32'(e_sl));
    reset     = r;
    start     = s;
    period    = per[CW-1:0];
    num_steps = num[SW-1:0];
    dir_in    = d;
`ifdef STEP_ABORT_EN
    abort     = ab;
`endif
    @(posedge clk);
    if (r) begin
      m_act = 1'b0;
      m_dir = 1'b0;
    end else if (!m_act) begin
      if (s) begin
        m_act  = 1'b1;
        m_t    = 1;
        m_pe   = (per < PW + 1) ? PW + 1 : per;
        m_num  = num;
        m_tend = num * m_pe + 1;
        m_dir  = d;
      end
    end else if (m_t == m_tend) begin
      m_act = 1'b0;
    end else begin
      if (ab) m_tend = m_t + 1;
      m_t++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; period = '0; num_steps = '0; dir_in = 1'b0;
`ifdef STEP_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    tick(1, 0, 0, 0, 0, 0);
    idle(2);
    // basic burst, then a foreign start while busy
    tick(0, 1, 10, 3, 1, 0);
    idle(14);
    tick(0, 1, 3, 2, 0, 0);
    idle(20);
    // zero steps
    tick(0, 1, 10, 0, 1, 0);
    idle(3);
    // clamped period
    tick(0, 1, 2, 3, 0, 0);
    idle(20);
    // reset during LOW of the second step, then a fresh command
    tick(0, 1, 10, 3, 1, 0);
    idle(15);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 7, 2, 1, 0);
    idle(18);
    // start in the DONE cycle is ignored, next cycle accepted
    tick(0, 1, 6, 1, 0, 0);
    idle(6);
    tick(0, 1, 5, 1, 1, 0);
    tick(0, 1, 5, 1, 1, 0);
    idle(8);
`ifdef STEP_ABORT_EN
    tick(0, 1, 10, 3, 1, 0);
    idle(11);
    tick(0, 0, 0, 0, 0, 1);
    idle(3);
`endif
    for (int i = 0; i < 3000; i++) begin
      bit r, s, d, ab;
      int per, num;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 3) == 0);
      d   = 1'($urandom_range(0, 1));
      per = $urandom_range(0, 14);
      num = $urandom_range(0, 4);
      ab  = 1'b0;
`ifdef STEP_ABORT_EN
      ab  = ($urandom_range(0, 59) == 0);
`endif
      tick(r, s, per, num, d, ab);
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
